// File: rtl/fracnet_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fracnet_mac_pipe                                           |
// | Description : Pipelined signed x signed/unsigned multiply-accumulate     |
// |               with valid/ready flow control, first/last-delimited burst  |
// |               accumulation, round-half-up right shift and signed         |
// |               saturation of the emitted result.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   rising-edge clock                                      |
// |   reset      in   synchronous active-high reset                          |
// |   in_valid   in   input beat valid                                       |
// |   in_ready   out  beat can be accepted this cycle                        |
// |   in_a       in   signed operand                     [A_WIDTH-1:0]       |
// |   in_b       in   operand, signedness by B_SIGNED    [B_WIDTH-1:0]       |
// |   in_first   in   beat restarts the accumulator                          |
// |   in_last    in   beat closes the burst, result is emitted               |
// |   out_valid  out  result valid                                           |
// |   out_ready  in   downstream accepts result                              |
// |   out_data   out  rounded/shifted/saturated result   [OUT_WIDTH-1:0]     |
// |   out_sat    out  out_data was clipped                                   |
// +--------------------------------------------------------------------------+
module fracnet_mac_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 8,
  parameter int B_SIGNED  = 0,
  parameter int ACC_WIDTH = 32,
  parameter int SHIFT     = 8,
  parameter int OUT_WIDTH = 16,
  parameter int NUM_STAGE = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [A_WIDTH-1:0]          in_a,
  input  logic [B_WIDTH-1:0]          in_b,
  input  logic                        in_first,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat
);

  localparam int c_pw = A_WIDTH + B_WIDTH + 1;  // exact product width
  localparam int c_np = NUM_STAGE - 3;          // number of product register stages

  // Saturation bounds at the (ACC_WIDTH+1)-bit rounding width; min = ~max.
  localparam logic signed [ACC_WIDTH:0] c_max =
      (ACC_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] c_min = ~c_max;

  // Whole pipeline moves in lockstep: it only stalls when a result is
  // parked at the output and downstream is not taking it.
  logic w_adv;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv & ~reset;

  // ---------------------------------------------------------------- S1
  logic signed [A_WIDTH-1:0] r_a;
  logic [B_WIDTH-1:0]        r_b;
  logic                      r_s1_vld;
  logic                      r_s1_first;
  logic                      r_s1_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_adv) begin
      r_a        <= in_a;
      r_b        <= in_b;
      r_s1_vld   <= in_valid;
      r_s1_first <= in_first;
      r_s1_last  <= in_last;
    end
  end

  // ---------------------------------------------------------------- multiply
  logic signed [c_pw-1:0] w_a_x;
  logic signed [c_pw-1:0] w_b_x;
  logic signed [c_pw-1:0] w_prod;

  assign w_a_x = c_pw'(r_a);

  generate
    if (B_SIGNED != 0) begin : g_b_signed
      assign w_b_x = c_pw'($signed(r_b));
    end else begin : g_b_unsigned
      assign w_b_x = c_pw'(r_b);
    end
  endgenerate

  // Both operands are sign-correct at c_pw bits and the true product fits,
  // so truncation to c_pw loses nothing.
  assign w_prod = w_a_x * w_b_x;

  // ---------------------------------------------------------------- S2..S(N-2)
  logic signed [c_pw-1:0] r_prod [c_np];
  logic [c_np-1:0]        r_p_vld;
  logic [c_np-1:0]        r_p_first;
  logic [c_np-1:0]        r_p_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < c_np; i++) begin
        r_prod[i] <= '0;
      end
      r_p_vld   <= '0;
      r_p_first <= '0;
      r_p_last  <= '0;
    end else if (w_adv) begin
      r_prod[0]    <= w_prod;
      r_p_vld[0]   <= r_s1_vld;
      r_p_first[0] <= r_s1_first;
      r_p_last[0]  <= r_s1_last;
      for (int i = 1; i < c_np; i++) begin
        r_prod[i]    <= r_prod[i-1];
        r_p_vld[i]   <= r_p_vld[i-1];
        r_p_first[i] <= r_p_first[i-1];
        r_p_last[i]  <= r_p_last[i-1];
      end
    end
  end

  // ---------------------------------------------------------------- accumulator
  logic signed [ACC_WIDTH-1:0] w_prod_sx;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_acc_vld;
  logic                        r_acc_last;

  assign w_prod_sx = ACC_WIDTH'(r_prod[c_np-1]);

  // Accumulation wraps modulo 2^ACC_WIDTH; clipping happens only at output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_acc_vld  <= 1'b0;
      r_acc_last <= 1'b0;
    end else if (w_adv) begin
      r_acc_vld  <= r_p_vld[c_np-1];
      r_acc_last <= r_p_last[c_np-1];
      if (r_p_vld[c_np-1]) begin
        r_acc <= r_p_first[c_np-1] ? w_prod_sx : (r_acc + w_prod_sx);
      end
    end
  end

  // ---------------------------------------------------------------- round/shift
  // One guard bit above the accumulator keeps the rounding add overflow-free.
  logic signed [ACC_WIDTH:0] w_acc_x;
  logic signed [ACC_WIDTH:0] w_rnd;

  assign w_acc_x = {r_acc[ACC_WIDTH-1], r_acc};

  generate
    if (SHIFT > 0) begin : g_rnd_shift
      localparam logic signed [ACC_WIDTH:0] c_half =
          (ACC_WIDTH+1)'(1) <<< (SHIFT - 1);
      assign w_rnd = (w_acc_x + c_half) >>> SHIFT;
    end else begin : g_rnd_pass
      assign w_rnd = w_acc_x;
    end
  endgenerate

  // ---------------------------------------------------------------- output
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_acc_vld & r_acc_last;
      if (r_acc_vld & r_acc_last) begin
        if (w_rnd > c_max) begin
          out_data <= c_max[OUT_WIDTH-1:0];
          out_sat  <= 1'b1;
        end else if (w_rnd < c_min) begin
          out_data <= c_min[OUT_WIDTH-1:0];
          out_sat  <= 1'b1;
        end else begin
          out_data <= w_rnd[OUT_WIDTH-1:0];
          out_sat  <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fracnet_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fracnet_mac_pipe                                        |
// | Description : Self-checking bench for fracnet_mac_pipe (default config   |
// |               plus a signed-B, zero-shift instance).                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fracnet_mac_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               in_valid, in_ready, in_first, in_last;
  logic               out_valid, out_ready, out_sat;
  logic signed [15:0] in_a;
  logic [7:0]         in_b;
  logic signed [15:0] out_data;

  logic               s_in_valid, s_in_ready, s_in_first, s_in_last;
  logic               s_out_valid, s_out_ready, s_out_sat;
  logic signed [15:0] s_in_a;
  logic [7:0]         s_in_b;
  logic signed [15:0] s_out_data;

  fracnet_mac_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  fracnet_mac_pipe #(.B_SIGNED(1), .SHIFT(0)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_first(s_in_first), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_sat(s_out_sat)
  );

  typedef struct {
    logic signed [15:0] a;
    logic [7:0]         b;
    bit                 first;
    bit                 last;
    logic signed [15:0] exp_data;
    bit                 exp_sat;
  } vec_t;

  typedef struct {
    logic signed [15:0] data;
    bit                 sat;
  } res_t;

  res_t sb_q[$];
  int   pop_cyc[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every accepted result is popped and compared in order.
  always @(negedge clk) begin
    res_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_result: got out_data=%0d with no result pending", out_data);
      end else begin
        e = sb_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_sat", out_sat, e.sat);
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Present one beat (called just after a rising edge); returns just after
  // the edge that accepted it.
  task automatic send(input logic signed [15:0] a, input logic [7:0] b,
                      input bit f, input bit l,
                      input logic signed [15:0] ed, input bit es);
    int   w;
    res_t r;
    in_a = a; in_b = b; in_first = f; in_last = l; in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stall_cnt++;
      w++;
      if (w > 200) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
        break;
      end
    end
    if (l) begin
      r.data = ed;
      r.sat  = es;
      sb_q.push_back(r);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic s_check(input logic signed [15:0] a, input logic [7:0] b,
                         input logic signed [15:0] ed, input bit es);
    int w;
    @(posedge clk); #1;
    s_in_a = a; s_in_b = b; s_in_first = 1'b1; s_in_last = 1'b1; s_in_valid = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", s_in_ready, 1);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    w = 0;
    while (!s_out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("t6_out_valid", s_out_valid, 1);
    chk("t6_out_data", s_out_data, ed);
    chk("t6_out_sat", s_out_sat, es);
  endtask

  vec_t vt[16];

  initial begin
    int t0;
    int w;

    vt[0]  = '{a: -16'sd3,     b: 8'd200, first: 1, last: 1, exp_data: -16'sd2,     exp_sat: 0};
    vt[1]  = '{a: 16'sd32767,  b: 8'd255, first: 1, last: 0, exp_data: 16'sd0,     exp_sat: 0};
    vt[2]  = '{a: 16'sd32767,  b: 8'd255, first: 0, last: 0, exp_data: 16'sd0,     exp_sat: 0};
    vt[3]  = '{a: 16'sd32767,  b: 8'd255, first: 0, last: 0, exp_data: 16'sd0,     exp_sat: 0};
    vt[4]  = '{a: 16'sd32767,  b: 8'd255, first: 0, last: 1, exp_data: 16'sd32767, exp_sat: 1};
    vt[5]  = '{a: -16'sd32768, b: 8'd255, first: 1, last: 1, exp_data: -16'sd32640, exp_sat: 0};
    vt[6]  = '{a: -16'sd32768, b: 8'd255, first: 1, last: 0, exp_data: 16'sd0,     exp_sat: 0};
    vt[7]  = '{a: -16'sd32768, b: 8'd255, first: 0, last: 1, exp_data: -16'sd32768, exp_sat: 1};
    vt[8]  = '{a: 16'sd128,    b: 8'd1,   first: 1, last: 1, exp_data: 16'sd1,     exp_sat: 0};
    vt[9]  = '{a: 16'sd127,    b: 8'd1,   first: 1, last: 1, exp_data: 16'sd0,     exp_sat: 0};
    vt[10] = '{a: -16'sd128,   b: 8'd1,   first: 1, last: 1, exp_data: 16'sd0,     exp_sat: 0};
    vt[11] = '{a: -16'sd129,   b: 8'd1,   first: 1, last: 1, exp_data: -16'sd1,    exp_sat: 0};
    vt[12] = '{a: 16'sd256,    b: 8'd1,   first: 1, last: 1, exp_data: 16'sd1,     exp_sat: 0};
    vt[13] = '{a: 16'sd256,    b: 8'd1,   first: 0, last: 1, exp_data: 16'sd2,     exp_sat: 0};
    vt[14] = '{a: 16'sd32767,  b: 8'd255, first: 1, last: 0, exp_data: 16'sd0,     exp_sat: 0};
    vt[15] = '{a: 16'sd32767,  b: 8'd1,   first: 0, last: 1, exp_data: 16'sd32767, exp_sat: 0};

    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_first = 1'b0; s_in_last = 1'b0;
    s_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Single beat: latency from presentation cycle to visible result
    t0 = cyc;
    send(-16'sd3, 8'd200, 1, 1, -16'sd2, 0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("t1_latency", cyc - t0, 4);
    drain();

    // Table-driven vectors, full throughput
    foreach (vt[i]) send(vt[i].a, vt[i].b, vt[i].first, vt[i].last, vt[i].exp_data, vt[i].exp_sat);
    drain();

    // Back-to-back single beats: one result per cycle, no input stalls
    stall_cnt = 0;
    pop_cyc.delete();
    for (int i = 1; i <= 8; i++) send(16'(i * 256), 8'd1, 1, 1, 16'(i), 0);
    drain();
    chk("t3_input_stalls", stall_cnt, 0);
    chk("t3_result_count", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) chk("t3_consecutive_span", pop_cyc[7] - pop_cyc[0], 7);

    // Output backpressure: result held, input blocked, nothing lost
    out_ready = 1'b0;
    fork
      begin
        for (int i = 10; i <= 14; i++) send(16'(i * 256), 8'd1, 1, 1, 16'(i), 0);
      end
      begin
        int ww;
        ww = 0;
        while (!out_valid && ww < 20) begin
          @(negedge clk);
          ww++;
        end
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("t4_hold_valid", out_valid, 1);
          chk("t4_hold_data", out_data, 10);
          chk("t4_hold_sat", out_sat, 0);
          chk("t4_in_ready_low", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a burst discards the partial sum
    send(16'sd1000, 8'd100, 1, 0, 16'sd0, 0);
    send(16'sd1000, 8'd100, 0, 0, 16'sd0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_in_ready_in_reset", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_out_valid_low", out_valid, 0);
    end
    @(posedge clk); #1;
    send(16'sd512, 8'd1, 0, 1, 16'sd2, 0);
    send(16'sd512, 8'd1, 1, 1, 16'sd2, 0);
    drain();

    // Signed B operand, no shift
    s_check(16'sd100,    8'hFF, -16'sd100,   0);
    s_check(-16'sd32768, 8'h80, 16'sd32767,  1);
    s_check(16'sd300,    8'h80, -16'sd32768, 1);
    s_check(-16'sd5,     8'h7F, -16'sd635,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
